lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed data_memory port (`address`, `write_data`, `mem_read`, `mem_write`, `read_data`) on behalf of the CPU datapath.
- Accepts byte-addressed byte/halfword/word requests over a valid/ready handshake and returns load data over a valid/ready response channel.
- Sub-word loads: extracts the lane and sign- or zero-extends it.
- Sub-word stores: read-modify-write, because the memory only stores whole words.

Parameters:
- ADDR_W, 8, word-index width of data_memory (depth = 2**ADDR_W words).
- DATA_W, 32, word width; fixed at 32, sub-word logic assumes 4 byte lanes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (IDLE only).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- req_signed  input  1  sign-extend sub-word loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load result (0 for stores and errors).
- resp_error  output  1  misaligned, reserved size, or out-of-range request.
- mem_address  output  ADDR_W  word index to data_memory.
- mem_write_data  output  32  word to write.
- mem_read  output  1  read enable; data_memory read is combinational.
- mem_write  output  1  write enable; data_memory writes on the clk edge ending the cycle.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - req_ready=1; resp_valid=0, resp_error=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - All latched request fields cleared.
- States: IDLE, RD, RMW_RD, WR, RESP. mem_read/mem_write are registered-decode outputs, high only in their states, never both high.
- IDLE:
  - req_ready=1. On req_valid at an edge, latch all request fields.
  - Error check: misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11 -> RESP with error=1. No memory access.
  - Otherwise: load -> RD; word store -> WR; byte/half store -> RMW_RD.
- RD (1 cycle):
  - mem_read=1, mem_address=addr[ADDR_W+1:2].
  - At the edge, capture read_data, shift the lane by addr[1:0], extend per size/signed into resp_rdata; go to RESP.
- RMW_RD (1 cycle):
  - mem_read=1.
  - At the edge, merge req_wdata low byte/half into the captured word at lane addr[1:0]; go to WR.
- WR (1 cycle):
  - mem_write=1, mem_write_data = merged word (word store: req_wdata unmodified).
  - Go to RESP; resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_error stable while resp_ready=0.
  - On resp_ready at an edge -> IDLE.
  - No new request is accepted in the same cycle (req_ready=0 outside IDLE).
- Latency, accept edge to resp_valid high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Addresses are truncated to mem_address; upper bits are ignored unless the optional feature is enabled.
- Reset mid-operation: abandons the transaction. mem_write drops immediately (asynchronously), so a partial RMW never writes. No response is issued.
- mem_read low outside RD/RMW_RD, so data_memory's high-Z output is never sampled.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: any nonzero req_addr[31:ADDR_W+2] is flagged in IDLE as an error (1-cycle path to RESP, resp_error=1, no memory access).
- Undefined: upper address bits are ignored and the access aliases into the memory.

Decomposition:
- Package lsu_pkg:
  - State encoding enum: IDLE=0, RD=1, RMW_RD=2, WR=3, RESP=4.
  - Size codes: SZ_BYTE, SZ_HALF, SZ_WORD.
  - Lane-merge and lane-extract helper functions.
- Sub-module lsu_lane_align (combinational):
  - Extract/extend for loads.
  - Byte-enable merge for stores.
  - Instantiated once, shared by RD and RMW_RD paths.

Test Plan:
- Preload word1=0x00000001. Word store 0xDEADBEEF @0x08, then word load @0x08 -> mem_write one cycle with mem_address=2; load returns 0xDEADBEEF, resp_error=0, resp_valid 2 cycles after accept.
- Byte store 0xAB @0x05 -> one mem_read cycle then one mem_write cycle with mem_write_data=0x0000AB01; resp_valid 3 cycles after accept.
- Byte loads @0x05 (word1 = 0x0000AB01):
  - signed -> 0xFFFFFFAB.
  - unsigned -> 0x000000AB.
  - signed halfword load @0x04 -> 0xFFFFAB01.
- Halfword store @0x03 and word load @0x06 -> resp_error=1 one cycle after accept; mem_read and mem_write never asserted; resp_rdata=0.
- resp_ready held low 5 cycles -> resp_valid and resp_rdata stable; req_ready=0 and a second req_valid is ignored until the response handshake completes.
- Assert reset during RMW_RD of a byte store @0x04 -> mem_write never asserts; target word unchanged; outputs at reset values; next request works normally.
- With LSU_RANGE_CHECK_EN: load @0x400 -> resp_error=1, no mem_read.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store memory master.
// Optional feature macro LSU_RANGE_CHECK_EN is consumed by lsu_mem_master.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Shift the addressed lane down to bit 0 and sign- or zero-extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input logic [1:0]  size,
                                                 input logic        sign_ext);
        logic [31:0] sh;
        sh = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: lane_extract = {{24{sign_ext & sh[7]}}, sh[7:0]};
            SZ_HALF: lane_extract = {{16{sign_ext & sh[15]}}, sh[15:0]};
            default: lane_extract = word;
        endcase
    endfunction

    // Replace the addressed lane of word with the low byte/half of wdata.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF;
                data = {24'b0, wdata[7:0]};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF;
                data = {16'b0, wdata[15:0]};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        lane_merge = (word & ~(mask << {offset, 3'b000})) | (data << {offset, 3'b000});
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational lane alignment: load extract/extend and store byte-lane merge.
// Shared between the RD and RMW_RD paths of lsu_mem_master.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    // Both views of the fetched word are computed every cycle; the FSM picks one.
    always_comb begin
        o_load   = lane_extract(i_word, i_offset, i_size, i_signed);
        o_merged = lane_merge(i_word, i_wdata, i_offset, i_size);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-addressed data_memory port.
// Sub-word stores are done as read-modify-write.
// Optional: define LSU_RANGE_CHECK_EN to flag addresses beyond the memory as errors.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_d;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_offset;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;

    logic              w_misalign;
    logic              w_range_err;
    logic              w_req_err;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

`ifdef LSU_RANGE_CHECK_EN
    assign w_range_err = |req_addr[31:ADDR_W+2];
`else
    // Upper address bits alias into the memory.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign w_range_err      = 1'b0;
`endif

    // Request legality, evaluated on the live request in IDLE.
    always_comb begin
        w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        w_req_err  = w_misalign || (req_size == 2'b11) || w_range_err;
    end

    lsu_lane_align u_lane_align (
        .i_word   (mem_read_data),
        .i_wdata  (r_wdata),
        .i_offset (r_offset),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load_data),
        .o_merged (w_merged)
    );

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err)                w_state_d = RESP;
                    else if (!req_write)          w_state_d = RD;
                    else if (req_size == SZ_WORD) w_state_d = WR;
                    else                          w_state_d = RMW_RD;
                end
            end
            RD:      w_state_d = RESP;
            RMW_RD:  w_state_d = WR;
            WR:      w_state_d = RESP;
            RESP:    if (resp_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // State register and latched request/response fields; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_widx   <= '0;
            r_offset <= 2'b00;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_widx   <= req_addr[ADDR_W+1:2];
                        r_offset <= req_addr[1:0];
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        r_rdata  <= '0;
                        r_error  <= w_req_err;
                    end
                end
                RD:      r_rdata <= w_load_data;
                RMW_RD:  r_wdata <= w_merged;
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register, so reset kills them at once.
    always_comb begin
        req_ready      = (r_state == IDLE);
        resp_valid     = (r_state == RESP);
        mem_read       = (r_state == RD) || (r_state == RMW_RD);
        mem_write      = (r_state == WR);
        mem_address    = r_widx;
        mem_write_data = r_wdata;
        resp_rdata     = r_rdata;
        resp_error     = r_error;
    end

endmodule
